// File: rtl/motion_sequencer.sv
// Command scheduler in front of the stepper controller: queues move/home commands and runs them one at a time.
// Latency: a push into an empty idle queue raises a start two cycles after the push edge; every command is followed by a DWELL gap.
// Backpressure: cmd_ready is low when the FIFO holds DEPTH entries or abort is high. Offers made while abort is high are dropped.
module motion_sequencer #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int DWELL       = 16,
    parameter int IDLE_HOLD   = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_home,
    input  logic [127:0]               cmd_steps,
    input  logic [127:0]               cmd_speed,
    input  logic                       abort,
    input  logic                       steppers_driving,
    output logic [127:0]               step_out,
    output logic [127:0]               speed_out,
    output logic                       start_driving,
    output logic                       start_homing,
    output logic                       stepper_enable,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       cmd_done,
    output logic                       ack_timeout
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int AKW = $clog2(ACK_TIMEOUT + 1);
    localparam int DWW = $clog2(DWELL + 1);
    localparam int IW  = $clog2(IDLE_HOLD + 1);

    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
    localparam logic [AKW-1:0] ACK_LAST   = AKW'(ACK_TIMEOUT - 1);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
    localparam logic [IW-1:0]  IDLE_LAST  = IW'(IDLE_HOLD - 1);

    // One queued command: homing flag plus four step lanes and four speed lanes.
    typedef struct packed {
        logic         home;
        logic [127:0] steps;
        logic [127:0] speed;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DWELL
    } state_t;

    state_t         state_q, state_d;
    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           home_q;
    logic [AKW-1:0] ack_cnt;
    logic [DWW-1:0] dwell_cnt;
    logic [IW-1:0]  idle_cnt;
    logic           push, pop;
    cmd_t           wr_entry, head;

    // cmd_ready only looks at the registered count, so a full FIFO never accepts even while popping.
    assign push     = cmd_valid && cmd_ready;
    assign pop      = (state_q == S_LOAD) && !abort;
    assign wr_entry = '{home: cmd_home, steps: cmd_steps, speed: cmd_speed};
    assign head     = mem[rd_ptr];
    assign fifo_count = count;

    // FIFO storage: plain memory, no reset needed because the count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; abort empties the queue in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything and parks the sequencer in DWELL.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_DWELL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count != '0) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_d = S_START;
                end
                S_START: begin
                    if (steppers_driving) begin
                        state_d = S_RUN;
                    end else if (ack_cnt == ACK_LAST) begin
                        state_d = S_DWELL;
                    end
                end
                S_RUN: begin
                    if (!steppers_driving) begin
                        state_d = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Decoded outputs; starts come straight from the state so reset or abort drops them without delay.
    always_comb begin
        start_driving = 1'b0;
        start_homing  = 1'b0;
        if ((state_q == S_START) || (state_q == S_RUN)) begin
            start_homing  = home_q;
            start_driving = !home_q;
        end
        busy      = (state_q != S_IDLE) || (count != '0);
        cmd_ready = !rst && !abort && (count < DEPTH_C);
    end

    // Head command is captured only in LOAD and then held for the whole START/RUN/DWELL window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_out  <= '0;
            speed_out <= '0;
            home_q    <= 1'b0;
        end else if (pop) begin
            step_out  <= head.steps;
            speed_out <= head.speed;
            home_q    <= head.home;
        end
    end

    // Acknowledge timer counts START cycles and saturates at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state_q != S_START) begin
            ack_cnt <= '0;
        end else if (ack_cnt != ACK_LAST) begin
            ack_cnt <= ack_cnt + AKW'(1);
        end
    end

    // Dwell timer restarts on DWELL entry and on every abort cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if ((state_q != S_DWELL) || abort) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + DWW'(1);
        end
    end

    // Completion pulse on a normal START/RUN -> DWELL step, plus a sticky flag when the controller never acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_done    <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            cmd_done <= !abort && (state_d == S_DWELL) &&
                        ((state_q == S_START) || (state_q == S_RUN));
            if (abort) begin
                ack_timeout <= 1'b0;
            end else if ((state_q == S_START) && !steppers_driving && (ack_cnt == ACK_LAST)) begin
                ack_timeout <= 1'b1;
            end
        end
    end

    // Motor power: on with any push or activity, off after IDLE_HOLD consecutive idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepper_enable <= 1'b0;
            idle_cnt       <= '0;
        end else if (push || busy) begin
            stepper_enable <= 1'b1;
            idle_cnt       <= '0;
        end else if (stepper_enable) begin
            if (idle_cnt == IDLE_LAST) begin
                stepper_enable <= 1'b0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer at default parameters.
// Inputs are driven and outputs are sampled on the falling edge, away from the active rising edge.
// Every wait on the DUT is bounded, and an expired bound counts as a failed comparison.
module tb_motion_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_home;
    logic [127:0] cmd_steps;
    logic [127:0] cmd_speed;
    logic         abort;
    logic         steppers_driving;
    logic [127:0] step_out;
    logic [127:0] speed_out;
    logic         start_driving;
    logic         start_homing;
    logic         stepper_enable;
    logic         busy;
    logic [2:0]   fifo_count;
    logic         cmd_done;
    logic         ack_timeout;

    int tests = 0;
    int fails = 0;

    motion_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_home         (cmd_home),
        .cmd_steps        (cmd_steps),
        .cmd_speed        (cmd_speed),
        .abort            (abort),
        .steppers_driving (steppers_driving),
        .step_out         (step_out),
        .speed_out        (speed_out),
        .start_driving    (start_driving),
        .start_homing     (start_homing),
        .stepper_enable   (stepper_enable),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .cmd_done         (cmd_done),
        .ack_timeout      (ack_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic h, input logic [127:0] st, input logic [127:0] sp, output int stall);
        cmd_home  = h;
        cmd_steps = st;
        cmd_speed = sp;
        cmd_valid = 1'b1;
        stall = 0;
        while (!cmd_ready && stall < 500) begin
            tick();
            stall++;
        end
        if (stall >= 500) check("push_timeout", 1, 0);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!(start_driving || start_homing) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("start_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("idle_timeout", 1, 0);
    endtask

    // Runs one command: waits for its start, checks it, holds the controller busy for 'hold' cycles, releases it.
    task automatic run_cmd(input logic h, input logic [127:0] st, input logic [127:0] sp,
                           input int hold, output int gap);
        wait_start(gap);
        check("start_homing_sel", start_homing, h);
        check("start_driving_sel", start_driving, !h);
        check("step_out_loaded", step_out, st);
        check("speed_out_loaded", speed_out, sp);
        steppers_driving = 1'b1;
        repeat (hold) tick();
        check("start_held_in_run", start_driving | start_homing, 1);
        check("step_out_stable", step_out, st);
        steppers_driving = 1'b0;
        tick();
        check("start_dropped", start_driving | start_homing, 0);
        check("cmd_done_pulse", cmd_done, 1);
    endtask

    initial begin
        int gap, stall, n, dones, highs;
        logic [127:0] st, sp;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_home = 1'b0;
        cmd_steps = '0;
        cmd_speed = '0;
        abort = 1'b0;
        steppers_driving = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_start_driving", start_driving, 0);
        check("rst_start_homing", start_homing, 0);
        check("rst_enable", stepper_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_step_out", step_out, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_ack_timeout", ack_timeout, 0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        // Test 1: single move, steps lane3 = 100, controller busy for 18 cycles
        st = {32'd100, 96'd0};
        sp = {32'd7, 32'd6, 32'd5, 32'd4};
        push(1'b0, st, sp, stall);
        check("t1_fifo_count", fifo_count, 1);
        check("t1_enable_after_push", stepper_enable, 1);
        run_cmd(1'b0, st, sp, 18, gap);
        // push edge -> IDLE -> LOAD -> START: two falling edges after the one following the push
        check("t1_start_latency", gap, 2);
        check("t1_lane3", step_out[127:96], 100);
        check("t1_no_ack_timeout", ack_timeout, 0);
        n = 0;
        dones = 0;
        highs = 0;
        while (busy && n < 100) begin
            dones += int'(cmd_done);
            highs += int'(start_driving | start_homing);
            tick();
            n++;
        end
        check("t1_dwell_len", n, 16);
        check("t1_done_once", dones, 1);
        check("t1_dwell_starts_low", highs, 0);

        // Test 2: five commands with DEPTH=4 behind a running blocker; 5th stalls, all run in order
        push(1'b0, 128'hB10C, 128'h1, stall);
        wait_start(gap);
        steppers_driving = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, {32'(10*i+3), 32'(10*i+2), 32'(10*i+1), 32'(10*i)}, ~{96'd0, 32'(i)}, stall);
            check("t2_no_stall_first4", stall, 0);
        end
        check("t2_fifo_full", fifo_count, 4);
        check("t2_ready_low_full", cmd_ready, 0);
        fork
            push(1'b0, {32'd43, 32'd42, 32'd41, 32'd40}, ~{96'd0, 32'd4}, stall);
            begin
                repeat (3) tick();
                steppers_driving = 1'b0;
            end
        join
        check("t2_fifth_stalled", stall > 0, 1);
        for (int i = 0; i < 5; i++) begin
            run_cmd(1'b0, {32'(10*i+3), 32'(10*i+2), 32'(10*i+1), 32'(10*i)}, ~{96'd0, 32'(i)}, 2, gap);
        end
        wait_idle();

        // Test 3: home then move, separated by DWELL plus IDLE and LOAD both-low cycles
        push(1'b1, 128'h11, 128'h22, stall);
        push(1'b0, 128'h33, 128'h44, stall);
        run_cmd(1'b1, 128'h11, 128'h22, 4, gap);
        run_cmd(1'b0, 128'h33, 128'h44, 4, gap);
        check("t3_gap_both_low", gap, 18);
        wait_idle();

        // Test 4: controller never acknowledges -> start held ACK_TIMEOUT cycles, sticky ack_timeout
        push(1'b0, 128'h55, 128'h66, stall);
        wait_start(gap);
        n = 0;
        while (start_driving && n < 200) begin
            tick();
            n++;
        end
        check("t4_start_high_len", n, 64);
        check("t4_cmd_done", cmd_done, 1);
        check("t4_ack_timeout", ack_timeout, 1);
        wait_idle();
        check("t4_ack_timeout_sticky", ack_timeout, 1);

        // Test 5: abort during RUN with three queued
        push(1'b0, 128'h77, 128'h88, stall);
        wait_start(gap);
        steppers_driving = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push(1'b0, 128'h100 + 128'(i), 128'h200, stall);
        check("t5_fifo_three", fifo_count, 3);
        abort = 1'b1;
        cmd_valid = 1'b1;
        #1;
        check("t5_ready_low_abort", cmd_ready, 0);
        tick();
        check("t5_starts_dropped", start_driving | start_homing, 0);
        check("t5_fifo_flushed", fifo_count, 0);
        check("t5_no_done", cmd_done, 0);
        check("t5_ack_cleared", ack_timeout, 0);
        tick();
        check("t5_push_ignored", fifo_count, 0);
        cmd_valid = 1'b0;
        abort = 1'b0;
        steppers_driving = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            dones += int'(cmd_done);
            tick();
        end
        check("t5_no_done_after", dones, 0);
        check("t5_idle", busy, 0);

        // Test 6: enable stays on exactly IDLE_HOLD idle cycles after the queue drains
        push(1'b0, 128'h99, 128'hAA, stall);
        run_cmd(1'b0, 128'h99, 128'hAA, 3, gap);
        wait_idle();
        n = 0;
        while (stepper_enable && !busy && n < 60000) begin
            tick();
            n++;
        end
        check("t6_idle_hold_len", n, 50000);
        check("t6_enable_off", stepper_enable, 0);

        // Test 7: reset in the middle of RUN clears outputs asynchronously
        push(1'b1, 128'hCC, 128'hDD, stall);
        wait_start(gap);
        steppers_driving = 1'b1;
        repeat (2) tick();
        check("t7_in_run", start_homing, 1);
        rst = 1'b1;
        #1;
        check("t7_rst_start_homing", start_homing, 0);
        check("t7_rst_start_driving", start_driving, 0);
        check("t7_rst_enable", stepper_enable, 0);
        check("t7_rst_step_out", step_out, 0);
        check("t7_rst_speed_out", speed_out, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_fifo", fifo_count, 0);
        steppers_driving = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
